// File: rtl/kmeans_centroid_div_if.sv
// Handshake/result bundle between the K-means controller and one centroid divider lane.
// fsm_state mirrors the divider FSM for observation only.
interface kmeans_centroid_div_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    // clr/acc_valid/start are single-cycle qualifiers sampled on the rising clock edge;
    // results are valid from the cycle done is high and hold until the next done.
    logic             clr;
    logic             acc_valid;
    logic [WIDTH-1:0] acc_data;
    logic             start;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] count;
    logic [1:0]       fsm_state;

    modport master (
        output clr, acc_valid, acc_data, start,
        input  busy, done, div_zero, quotient, remainder, sum, count, fsm_state
    );

    modport slave (
        input  clr, acc_valid, acc_data, start,
        output busy, done, div_zero, quotient, remainder, sum, count, fsm_state
    );
endinterface

// File: rtl/kmeans_centroid_div.sv
// Centroid lane: accumulates coordinates into sum/count, then divides sum by count
// with a restoring shift-subtract divider producing one quotient bit per cycle.
module kmeans_centroid_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    kmeans_centroid_div_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic             dz_r;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] count_r;

    logic             acc_en;
    logic             last_bit;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] rem_next;

    assign acc_en   = (state == IDLE) && !bus.start && bus.acc_valid;
    assign last_bit = (idx == IDX_W'(WIDTH - 1));

    // Trial subtract is one bit wider so the shifted remainder can never overflow.
    always_comb begin
        trial    = {part_rem, dividend[WIDTH-1]};
        diff     = trial - {1'b0, divisor};
        fits     = (trial >= {1'b0, divisor});
        rem_next = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.start) state_nxt = (count_r != '0) ? DIV : DONE;
            DIV:  if (last_bit)  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.fsm_state = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r    <= '0;
            count_r  <= '0;
            dividend <= '0;
            divisor  <= '0;
            part_rem <= '0;
            idx      <= '0;
            quo_r    <= '0;
            rem_r    <= '0;
            dz_r     <= 1'b0;
        end else begin
            // clr works in every state; a running division uses its own latched operands.
            if (bus.clr) begin
                sum_r   <= acc_en ? bus.acc_data : '0;
                count_r <= acc_en ? CNT_W'(1) : '0;
            end else if (acc_en) begin
                sum_r <= sum_r + bus.acc_data;
                if (count_r != '1) count_r <= count_r + 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (count_r != '0) begin
                            dividend <= sum_r;
                            divisor  <= WIDTH'(count_r);
                            part_rem <= '0;
                            idx      <= '0;
                        end else begin
                            quo_r <= '1;
                            rem_r <= sum_r;
                            dz_r  <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    // Quotient bits shift in behind the consumed dividend bits.
                    part_rem <= rem_next;
                    dividend <= {dividend[WIDTH-2:0], fits};
                    idx      <= idx + 1'b1;
                    if (last_bit) begin
                        quo_r <= {dividend[WIDTH-2:0], fits};
                        rem_r <= rem_next;
                        dz_r  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient  = quo_r;
    assign bus.remainder = rem_r;
    assign bus.div_zero  = dz_r;
    assign bus.sum       = sum_r;
    assign bus.count     = count_r;
endmodule
